// File: rtl/size_count_pkg.sv
// size_count_pkg: shared FSM states and default sizing for size_queue_count
package size_count_pkg;
    typedef enum logic {IDLE, COUNT} state_e;
    localparam int DEF_SIZE_W = 32;
    localparam int DEF_DEPTH  = 4;
    localparam int ORPHAN_W   = 8;
endpackage

// File: rtl/size_fifo.sv
// size_fifo: first-word-fall-through synchronous FIFO holding queued transfer sizes
module size_fifo #(
    parameter int SIZE_W = 32,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [SIZE_W-1:0] din,
    output logic [SIZE_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);
    logic [SIZE_W-1:0] mem_q [DEPTH];
    logic [SIZE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0]  cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full  = cnt_q == LVL_W'(DEPTH);
    assign empty = cnt_q == '0;
    assign level = cnt_q;
    assign dout  = mem_q[rd_q];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d  = do_push ? wr_q + PTR_W'(1) : wr_q;
        rd_d  = do_pop ? rd_q + PTR_W'(1) : rd_q;
        cnt_d = (do_push && !do_pop) ? cnt_q + LVL_W'(1) :
                (!do_push && do_pop) ? cnt_q - LVL_W'(1) : cnt_q;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) mem_q <= mem_d;
endmodule

// File: rtl/size_queue_count.sv
// size_queue_count: queued size counter with last-beat flag; SIZE_QUEUE_COUNT_ORPHAN_EN adds orphan tracking
module size_queue_count
    import size_count_pkg::*;
#(
    parameter int SIZE_W = DEF_SIZE_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic [SIZE_W-1:0]   size,
    input  logic                size_valid,
    output logic                size_ready,
    input  logic                data_start,
    output logic                last,
    output logic                busy,
    output logic [SIZE_W-1:0]   remaining,
    output logic [LVL_W-1:0]    level
`ifdef SIZE_QUEUE_COUNT_ORPHAN_EN
    ,
    output logic                orphan,
    output logic [ORPHAN_W-1:0] orphan_cnt
`endif
);
    state_e            state_q, state_d;
    logic [SIZE_W-1:0] rem_q, rem_d, head;
    logic              full, empty, push, pop;

    // zero-length sizes complete the handshake but never reach the queue
    assign push       = size_valid && size_ready && size != '0;
    assign size_ready = !full;
    assign busy       = state_q == COUNT;
    assign last       = busy && rem_q == SIZE_W'(1);
    assign remaining  = rem_q;

    size_fifo #(.SIZE_W(SIZE_W), .DEPTH(DEPTH)) u_fifo (
        .clock(clock),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .din  (size),
        .dout (head),
        .full (full),
        .empty(empty),
        .level(level)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pop     = 1'b0;
        if (state_q == IDLE) begin
            if (!empty) begin
                pop     = 1'b1;
                state_d = COUNT;
                rem_d   = head;
            end
        end else if (data_start) begin
            if (!last) rem_d = rem_q - SIZE_W'(1);
            else if (!empty) begin
                pop   = 1'b1;
                rem_d = head;
            end else begin
                state_d = IDLE;
                rem_d   = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

`ifdef SIZE_QUEUE_COUNT_ORPHAN_EN
    logic                orphan_q, orphan_d, beat_idle;
    logic [ORPHAN_W-1:0] ocnt_q, ocnt_d;

    assign orphan     = orphan_q;
    assign orphan_cnt = ocnt_q;

    always_comb begin
        beat_idle = data_start && state_q == IDLE;
        orphan_d  = orphan_q || beat_idle;
        ocnt_d    = (beat_idle && ocnt_q != '1) ? ocnt_q + ORPHAN_W'(1) : ocnt_q;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            orphan_q <= 1'b0;
            ocnt_q   <= '0;
        end else begin
            orphan_q <= orphan_d;
            ocnt_q   <= ocnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_size_queue_count.sv
// tb_size_queue_count: table-driven check of queueing, beat counting, back-pressure and reset
module tb_size_queue_count;
    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        size_valid = 1'b0;
    logic        data_start = 1'b0;
    logic [31:0] size = '0;
    logic        size_ready, last, busy;
    logic [31:0] remaining;
    logic [2:0]  level;
`ifdef SIZE_QUEUE_COUNT_ORPHAN_EN
    logic        orphan;
    logic [7:0]  orphan_cnt;
`endif

    always #5 clock = ~clock;

    size_queue_count dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .size      (size),
        .size_valid(size_valid),
        .size_ready(size_ready),
        .data_start(data_start),
        .last      (last),
        .busy      (busy),
        .remaining (remaining),
        .level     (level)
`ifdef SIZE_QUEUE_COUNT_ORPHAN_EN
        ,
        .orphan    (orphan),
        .orphan_cnt(orphan_cnt)
`endif
    );

    typedef struct {
        logic        sv;
        logic [31:0] size;
        logic        ds;
        logic        busy;
        logic        last;
        logic        rdy;
        logic [31:0] rem;
        logic [2:0]  lvl;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic add(input int sv, input int sz, input int ds, input int b, input int l,
                       input int r, input int rem, input int lv);
        vec_t v;
        v.sv   = sv != 0;
        v.size = 32'(sz);
        v.ds   = ds != 0;
        v.busy = b != 0;
        v.last = l != 0;
        v.rdy  = r != 0;
        v.rem  = 32'(rem);
        v.lvl  = 3'(lv);
        vecs.push_back(v);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " last"}, 32'(last), 0);
        chk({tag, " rdy"}, 32'(size_ready), 1);
        chk({tag, " rem"}, remaining, 0);
        chk({tag, " lvl"}, 32'(level), 0);
    endtask

    initial begin
        //  sv size ds | busy last rdy rem lvl  (outputs seen before the edge)
        add(1, 5, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 1, 1, 0, 1, 5, 0);
        add(0, 0, 1, 1, 0, 1, 4, 0);
        add(0, 0, 1, 1, 0, 1, 3, 0);
        add(0, 0, 1, 1, 0, 1, 2, 0);
        add(0, 0, 1, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 3, 0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0, 1, 0, 1);
        add(1, 2, 1, 1, 0, 1, 3, 1);
        add(0, 0, 1, 1, 0, 1, 2, 2);
        add(0, 0, 1, 1, 1, 1, 1, 2);
        add(0, 0, 1, 1, 1, 1, 1, 1);
        add(0, 0, 1, 1, 0, 1, 2, 0);
        add(0, 0, 1, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0);
        add(1, 2, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 1, 1, 0, 1, 2, 0);
        add(0, 0, 1, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 4, 0, 0, 0, 1, 0, 0);
        add(1, 5, 0, 0, 0, 1, 0, 1);
        add(1, 6, 0, 1, 0, 1, 4, 1);
        add(1, 7, 0, 1, 0, 1, 4, 2);
        add(1, 8, 0, 1, 0, 1, 4, 3);
        add(1, 9, 0, 1, 0, 0, 4, 4);
        add(1, 9, 1, 1, 0, 0, 4, 4);
        add(1, 9, 1, 1, 0, 0, 3, 4);
        add(1, 9, 1, 1, 0, 0, 2, 4);
        add(1, 9, 1, 1, 1, 0, 1, 4);
        add(1, 9, 0, 1, 0, 1, 5, 3);
        add(0, 0, 0, 1, 0, 0, 5, 4);

        tick;
        tick;
        rst_n = 1'b1;
        chk_idle("reset");
`ifdef SIZE_QUEUE_COUNT_ORPHAN_EN
        chk("reset orphan", 32'(orphan), 0);
        chk("reset orphan_cnt", 32'(orphan_cnt), 0);
`endif

        foreach (vecs[i]) begin
            size_valid = vecs[i].sv;
            size       = vecs[i].size;
            data_start = vecs[i].ds;
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d last", i), 32'(last), 32'(vecs[i].last));
            chk($sformatf("v%0d rdy", i), 32'(size_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d rem", i), remaining, vecs[i].rem);
            chk($sformatf("v%0d lvl", i), 32'(level), 32'(vecs[i].lvl));
            tick;
        end
        size_valid = 1'b0;
        data_start = 1'b0;

        // reset mid-transfer with remaining=3 and two sizes queued
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk_idle("clean");
        size_valid = 1'b1;
        size = 3;
        tick;
        size = 4;
        tick;
        size = 5;
        tick;
        size_valid = 1'b0;
        chk("mid busy", 32'(busy), 1);
        chk("mid rem", remaining, 3);
        chk("mid lvl", 32'(level), 2);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk_idle("midrst");
        data_start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("post%0d last", k), 32'(last), 0);
            chk($sformatf("post%0d busy", k), 32'(busy), 0);
            tick;
        end

`ifdef SIZE_QUEUE_COUNT_ORPHAN_EN
        for (int k = 0; k < 300; k++) tick;
        chk("orphan", 32'(orphan), 1);
        chk("orphan_cnt", 32'(orphan_cnt), 255);
`endif
        data_start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
